// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO controller driving tristate pin buffers, with
// synchronised/edge-detected readback. Define GPIO_DEBOUNCE_EN to add input debounce.
module gpio_ctrl #(
    parameter int NUM_GPIO     = 8,
    parameter int DEBOUNCE_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [2:0]          addr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic                ack,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oen,
    output logic                irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_STAT = 3'd2;
    localparam logic [2:0] ADDR_MASK = 3'd3;
    localparam logic [2:0] ADDR_POL  = 3'd4;
    localparam logic [2:0] ADDR_OUTL = 3'd5;

    typedef enum logic [2:0] {
        ARM_WAIT0,
        ARM_WAIT1,
        ARM_WAIT2,
        ARM_SETTLE,
        ARM_ON
    } arm_state_e;

    arm_state_e arm_q, arm_d;

    logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_GPIO-1:0] pin_val;
    logic [NUM_GPIO-1:0] edge_evt;
    logic                sample_tick;
    logic                armed;

    logic [NUM_GPIO-1:0] out_q, out_d;
    logic [NUM_GPIO-1:0] dir_q, dir_d;
    logic [NUM_GPIO-1:0] stat_q, stat_d;
    logic [NUM_GPIO-1:0] mask_q, mask_d;
    logic [NUM_GPIO-1:0] pol_q, pol_d;
    logic [NUM_GPIO-1:0] rd_field;
    logic [NUM_GPIO-1:0] wdata;
    logic [31:0]         rdata_q, rdata_d;
    logic                ack_q;
    logic                irq_q;
    logic                wr_en;

    logic                unused_wdata;

    assign wr_en        = stb & we;
    assign wdata        = data_in[NUM_GPIO-1:0];
    assign unused_wdata = ^data_in;

    // Two-flop synchroniser on the asynchronous pin readback; prev holds the
    // conditioned value one cycle back for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= pin_val;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int PRESC_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_DIV - 1);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [NUM_GPIO-1:0] hist0_q, hist1_q, hist2_q;
    logic [NUM_GPIO-1:0] deb_q;

    assign sample_tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if (sample_tick) begin
            presc_d = '0;
        end
    end

    // A pin only changes state once three consecutive tick samples agree.
    assign pin_val = (hist0_q & hist1_q & hist2_q)
                   | (deb_q & (hist0_q | hist1_q | hist2_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
            deb_q   <= '0;
        end else begin
            presc_q <= presc_d;
            deb_q   <= pin_val;
            if (sample_tick) begin
                hist0_q <= sync2_q;
                hist1_q <= hist0_q;
                hist2_q <= hist1_q;
            end
        end
    end
`else
    logic unused_div;

    assign unused_div  = (DEBOUNCE_DIV != 0);
    assign sample_tick = 1'b1;
    assign pin_val     = sync2_q;
`endif

    // Hold-off after reset so the synchroniser (and debounce) fill is never seen
    // as an edge; with debounce an extra settle cycle lets prev catch pin_val.
    always_comb begin
        arm_d = arm_q;
        case (arm_q)
            ARM_WAIT0: if (sample_tick) arm_d = ARM_WAIT1;
            ARM_WAIT1: if (sample_tick) arm_d = ARM_WAIT2;
`ifdef GPIO_DEBOUNCE_EN
            ARM_WAIT2: if (sample_tick) arm_d = ARM_SETTLE;
            ARM_SETTLE: arm_d = ARM_ON;
`else
            ARM_WAIT2: arm_d = ARM_ON;
`endif
            default: arm_d = ARM_ON;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= ARM_WAIT0;
        end else begin
            arm_q <= arm_d;
        end
    end

    assign armed    = (arm_q == ARM_ON);
    assign edge_evt = armed ? ((pol_q & pin_val & ~prev_q) | (~pol_q & ~pin_val & prev_q))
                            : '0;

    // Register writes; an edge event on a bit overrides a same-cycle W1C of it.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        pol_d  = pol_q;
        stat_d = stat_q | edge_evt;
        if (wr_en) begin
            case (addr)
                ADDR_DATA: out_d  = wdata;
                ADDR_DIR:  dir_d  = wdata;
                ADDR_STAT: stat_d = (stat_q & ~wdata) | edge_evt;
                ADDR_MASK: mask_d = wdata;
                ADDR_POL:  pol_d  = wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_field = '0;
        case (addr)
            ADDR_DATA: rd_field = pin_val;
            ADDR_DIR:  rd_field = dir_q;
            ADDR_STAT: rd_field = stat_q;
            ADDR_MASK: rd_field = mask_q;
            ADDR_POL:  rd_field = pol_q;
            ADDR_OUTL: rd_field = out_q;
            default:   rd_field = '0;
        endcase
        rdata_d = '0;
        if (stb) begin
            rdata_d[NUM_GPIO-1:0] = rd_field;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            stat_q  <= '0;
            mask_q  <= '0;
            pol_q   <= '1;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            pol_q   <= pol_d;
            rdata_q <= rdata_d;
            ack_q   <= stb;
            irq_q   <= |(stat_q & mask_q);
        end
    end

    assign gpio_out = out_q;
    assign gpio_oen = ~dir_q;
    assign data_out = rdata_q;
    assign ack      = ack_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scenario tasks plus a randomized run against a
// pin-history reference model of gpio_ctrl.
`timescale 1ns/1ps
module tb_gpio_ctrl;

    localparam int NG  = 8;
    localparam int DIV = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int SETTLE = 40;
`else
    localparam int SETTLE = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stb;
    logic          we;
    logic [2:0]    addr;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          ack;
    logic          irq;
    logic [NG-1:0] gpio_in;
    logic [NG-1:0] gpio_out;
    logic [NG-1:0] gpio_oen;

    int testsRun    = 0;
    int testsFailed = 0;

    gpio_ctrl #(.NUM_GPIO(NG), .DEBOUNCE_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oen (gpio_oen),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: software sees the pin value from two edges ago, edges
    // count only once three edges have passed since reset.
    logic [NG-1:0] mOut, mDir, mStat, mMask, mPol;
    logic          mIrq, mAck;
    logic [31:0]   mData;
    logic [NG-1:0] pinHist[$];
    int            edgesSinceReset;

    task automatic modelReset();
        mOut  = '0;
        mDir  = '0;
        mStat = '0;
        mMask = '0;
        mPol  = '1;
        mIrq  = 1'b0;
        mAck  = 1'b0;
        mData = '0;
        pinHist.delete();
        repeat (3) pinHist.push_back('0);
        edgesSinceReset = 0;
    endtask

    task automatic step();
        logic          sStb, sWe, wasRst;
        logic [2:0]    sAddr;
        logic [31:0]   sData;
        logic [NG-1:0] sIn, pinNow, pinPrev, evt, rd, clr;
        sStb   = stb;
        sWe    = we;
        sAddr  = addr;
        sData  = data_in;
        sIn    = gpio_in;
        wasRst = rst;
        @(posedge clk);
        #1;
        if (wasRst || rst) begin
            modelReset();
        end else begin
            pinNow  = pinHist[pinHist.size() - 2];
            pinPrev = pinHist[pinHist.size() - 3];
            evt = '0;
            if (edgesSinceReset >= 3) begin
                for (int i = 0; i < NG; i++) begin
                    if (mPol[i] && pinNow[i] && !pinPrev[i]) evt[i] = 1'b1;
                    if (!mPol[i] && !pinNow[i] && pinPrev[i]) evt[i] = 1'b1;
                end
            end
            case (sAddr)
                3'd0:    rd = pinNow;
                3'd1:    rd = mDir;
                3'd2:    rd = mStat;
                3'd3:    rd = mMask;
                3'd4:    rd = mPol;
                3'd5:    rd = mOut;
                default: rd = '0;
            endcase
            mIrq  = |(mStat & mMask);
            mAck  = sStb;
            mData = sStb ? {{(32-NG){1'b0}}, rd} : 32'd0;
            clr   = '0;
            if (sStb && sWe) begin
                case (sAddr)
                    3'd0:    mOut  = sData[NG-1:0];
                    3'd1:    mDir  = sData[NG-1:0];
                    3'd2:    clr   = sData[NG-1:0];
                    3'd3:    mMask = sData[NG-1:0];
                    3'd4:    mPol  = sData[NG-1:0];
                    default: ;
                endcase
            end
            mStat = (mStat & ~clr) | evt;
            pinHist.push_back(sIn);
            if (pinHist.size() > 4) void'(pinHist.pop_front());
            edgesSinceReset++;
        end
    endtask

    task automatic busAccess(input logic w, input logic [2:0] a, input logic [31:0] d,
                             output logic [31:0] rdata, output logic ackHi, output logic ackLo);
        stb = 1'b1; we = w; addr = a; data_in = d;
        step();
        rdata = data_out;
        ackHi = ack;
        stb = 1'b0; we = 1'b0;
        step();
        ackLo = ack;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ah, al;
        gpio_in = 8'hFF; stb = 0; we = 0; addr = 0; data_in = 0;
        rst = 1'b1;
        modelReset();
        #2;
        testsRun++; if (gpio_oen !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_oen got %h want ff", gpio_oen); end
        testsRun++; if (gpio_out !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out got %h want 00", gpio_out); end
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
        testsRun++; if (ack !== 1'b0 || data_out !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_bus got ack=%b data=%h want 0/0", ack, data_out); end
        step(); step();
        rst = 1'b0;
        repeat (SETTLE) step();
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_stat got %h want 0", rd); end
        testsRun++; if (ah !== 1'b1 || al !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ack got %b%b want 10", ah, al); end
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_irq_after got %b want 0", irq); end
        busAccess(1'b0, 3'd0, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h0000_00FF) begin testsFailed++; $display("[TB] FAIL reset_data got %h want ff", rd); end
        busAccess(1'b0, 3'd4, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h0000_00FF) begin testsFailed++; $display("[TB] FAIL reset_pol got %h want ff", rd); end
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        logic ah, al;
        stb = 1; we = 1; addr = 3'd1; data_in = 32'h0F;
        step();
        testsRun++; if (gpio_oen !== 8'hF0) begin testsFailed++; $display("[TB] FAIL dir_oen got %h want f0", gpio_oen); end
        testsRun++; if (ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL dir_ack got %b want 1", ack); end
        addr = 3'd0; data_in = 32'hA5;
        step();
        testsRun++; if (gpio_out !== 8'hA5) begin testsFailed++; $display("[TB] FAIL data_out_pins got %h want a5", gpio_out); end
        testsRun++; if (ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL data_ack got %b want 1", ack); end
        stb = 0; we = 0;
        step();
        testsRun++; if (ack !== 1'b0 || data_out !== 32'd0) begin testsFailed++; $display("[TB] FAIL idle_bus got ack=%b data=%h want 0/0", ack, data_out); end
        busAccess(1'b0, 3'd5, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'hA5 || ah !== 1'b1 || al !== 1'b0) begin testsFailed++; $display("[TB] FAIL outl_read got %h ack %b%b want a5 10", rd, ah, al); end
        busAccess(1'b1, 3'd5, 32'h00, rd, ah, al);
        busAccess(1'b0, 3'd5, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'hA5) begin testsFailed++; $display("[TB] FAIL outl_write_ignored got %h want a5", rd); end
        busAccess(1'b1, 3'd3, 32'hABCD_EF5A, rd, ah, al);
        busAccess(1'b0, 3'd3, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h0000_005A) begin testsFailed++; $display("[TB] FAIL mask_upper_bits got %h want 5a", rd); end
        busAccess(1'b1, 3'd3, 32'd0, rd, ah, al);
        busAccess(1'b1, 3'd6, 32'hFFFF_FFFF, rd, ah, al);
        busAccess(1'b0, 3'd6, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'd0 || ah !== 1'b1) begin testsFailed++; $display("[TB] FAIL addr6 got %h ack %b want 0 1", rd, ah); end
    endtask

    task automatic test_back_to_back();
        stb = 1; we = 0; addr = 3'd1;
        step();
        testsRun++; if (ack !== 1'b1 || data_out !== 32'h0F) begin testsFailed++; $display("[TB] FAIL b2b_dir got ack=%b %h want 1 0f", ack, data_out); end
        addr = 3'd5;
        step();
        testsRun++; if (ack !== 1'b1 || data_out !== 32'hA5) begin testsFailed++; $display("[TB] FAIL b2b_outl got ack=%b %h want 1 a5", ack, data_out); end
        addr = 3'd4;
        step();
        testsRun++; if (ack !== 1'b1 || data_out !== 32'hFF) begin testsFailed++; $display("[TB] FAIL b2b_pol got ack=%b %h want 1 ff", ack, data_out); end
        stb = 0;
        step();
        testsRun++; if (ack !== 1'b0 || data_out !== 32'd0) begin testsFailed++; $display("[TB] FAIL b2b_end got ack=%b %h want 0 0", ack, data_out); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        logic ah, al;
        busAccess(1'b1, 3'd4, 32'hFF, rd, ah, al);
        busAccess(1'b1, 3'd3, 32'h01, rd, ah, al);
        gpio_in = 8'h00;
        repeat (5) step();
        busAccess(1'b1, 3'd2, 32'hFF, rd, ah, al);
        gpio_in = 8'h01;
        repeat (3) step();
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_early got %b want 0", irq); end
        step();
        testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL irq_rise got %b want 1", irq); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h01) begin testsFailed++; $display("[TB] FAIL stat_rise got %h want 01", rd); end
        busAccess(1'b1, 3'd2, 32'h01, rd, ah, al);
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL irq_clear got %b want 0", irq); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL stat_clear got %h want 00", rd); end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd;
        logic ah, al;
        busAccess(1'b1, 3'd3, 32'h00, rd, ah, al);
        busAccess(1'b1, 3'd4, 32'hFD, rd, ah, al);
        gpio_in = 8'h03;
        repeat (5) step();
        busAccess(1'b1, 3'd2, 32'hFF, rd, ah, al);
        gpio_in = 8'h01;
        step(); step();
        stb = 1; we = 1; addr = 3'd2; data_in = 32'h02;
        step();
        stb = 0; we = 0;
        step();
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h02) begin testsFailed++; $display("[TB] FAIL set_wins got %h want 02", rd); end
        busAccess(1'b1, 3'd2, 32'h02, rd, ah, al);
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL w1c_quiet got %h want 00", rd); end
    endtask

    task automatic test_pol_no_event();
        logic [31:0] rd;
        logic ah, al;
        busAccess(1'b1, 3'd4, 32'h00, rd, ah, al);
        repeat (4) step();
        busAccess(1'b1, 3'd4, 32'hFF, rd, ah, al);
        repeat (4) step();
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL pol_write_event got %h want 00", rd); end
    endtask

    task automatic test_mask_late();
        logic [31:0] rd;
        logic ah, al;
        busAccess(1'b1, 3'd3, 32'h00, rd, ah, al);
        busAccess(1'b1, 3'd2, 32'hFF, rd, ah, al);
        gpio_in = 8'h05;
        repeat (6) step();
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL masked_irq got %b want 0", irq); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h04) begin testsFailed++; $display("[TB] FAIL masked_stat got %h want 04", rd); end
        stb = 1; we = 1; addr = 3'd3; data_in = 32'h04;
        step();
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_edge_irq got %b want 0", irq); end
        stb = 0; we = 0;
        step();
        testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL mask_late_irq got %b want 1", irq); end
        busAccess(1'b1, 3'd2, 32'h04, rd, ah, al);
        testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_late_clear got %b want 0", irq); end
        busAccess(1'b1, 3'd3, 32'h00, rd, ah, al);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        logic ah, al;
        stb = 1; we = 1; addr = 3'd1; data_in = 32'hFF;
        step();
        testsRun++; if (gpio_oen !== 8'h00 || ack !== 1'b1) begin testsFailed++; $display("[TB] FAIL pre_reset got oen=%h ack=%b want 00 1", gpio_oen, ack); end
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        testsRun++; if (ack !== 1'b0 || data_out !== 32'd0) begin testsFailed++; $display("[TB] FAIL midrst_bus got ack=%b data=%h want 0 0", ack, data_out); end
        testsRun++; if (gpio_oen !== 8'hFF || gpio_out !== 8'h00) begin testsFailed++; $display("[TB] FAIL midrst_pins got oen=%h out=%h want ff 00", gpio_oen, gpio_out); end
        stb = 0; we = 0;
        step();
        rst = 1'b0;
        repeat (SETTLE) step();
        busAccess(1'b0, 3'd1, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL midrst_dir got %h want 00", rd); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL midrst_stat got %h want 00", rd); end
    endtask

`ifndef GPIO_DEBOUNCE_EN
    task automatic test_random();
        rst = 1'b1;
        modelReset();
        step();
        rst = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            gpio_in = gpio_in ^ NG'($urandom & $urandom & $urandom);
            stb     = ($urandom_range(0, 1) == 1);
            we      = ($urandom_range(0, 1) == 1);
            addr    = 3'($urandom_range(0, 7));
            data_in = $urandom;
            step();
            testsRun++; if (gpio_out !== mOut) begin testsFailed++; $display("[TB] FAIL rnd_out n=%0d got %h want %h", n, gpio_out, mOut); end
            testsRun++; if (gpio_oen !== ~mDir) begin testsFailed++; $display("[TB] FAIL rnd_oen n=%0d got %h want %h", n, gpio_oen, ~mDir); end
            testsRun++; if (ack !== mAck) begin testsFailed++; $display("[TB] FAIL rnd_ack n=%0d got %b want %b", n, ack, mAck); end
            testsRun++; if (data_out !== mData) begin testsFailed++; $display("[TB] FAIL rnd_data n=%0d got %h want %h", n, data_out, mData); end
            testsRun++; if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL rnd_irq n=%0d got %b want %b", n, irq, mIrq); end
        end
        stb = 0; we = 0;
    endtask
`else
    task automatic test_debounce();
        logic [31:0] rd;
        logic ah, al, seen;
        int waited;
        gpio_in = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (SETTLE) step();
        busAccess(1'b1, 3'd2, 32'hFF, rd, ah, al);
        busAccess(1'b1, 3'd3, 32'h08, rd, ah, al);
        gpio_in[3] = 1'b1;
        repeat (5) step();
        gpio_in[3] = 1'b0;
        repeat (40) step();
        busAccess(1'b0, 3'd0, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL glitch_data got %h want 00", rd); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h00) begin testsFailed++; $display("[TB] FAIL glitch_stat got %h want 00", rd); end
        gpio_in[3] = 1'b1;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 24) begin
            step();
            waited++;
            seen = irq;
        end
        testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL deb_irq got %b want 1 within 24 cycles", seen); end
        busAccess(1'b0, 3'd0, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h08) begin testsFailed++; $display("[TB] FAIL deb_data got %h want 08", rd); end
        busAccess(1'b0, 3'd2, 32'd0, rd, ah, al);
        testsRun++; if (rd !== 32'h08) begin testsFailed++; $display("[TB] FAIL deb_stat got %h want 08", rd); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_bus();
        test_back_to_back();
`ifndef GPIO_DEBOUNCE_EN
        test_edge_irq();
        test_set_wins();
        test_pol_no_event();
        test_mask_late();
`endif
        test_reset_mid_access();
`ifndef GPIO_DEBOUNCE_EN
        test_random();
`else
        test_debounce();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
